line_scheduler: RTL and testbench

LINE_SCHEDULER -- requirements
Module: line_scheduler

---
 rtl/datatape_pkg.sv | 27 ++
 rtl/line_buf.sv | 24 ++
 rtl/line_scheduler.sv | 211 +++++++++++++++++++++
 tb/tb_line_scheduler.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/datatape_pkg.sv
// Shared types and constants for the datatape line scheduler.
// Holds the drain state encoding, the idle byte and the line CRC-8 (poly 0x07) helper.
package datatape_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR_SYNC,
    ST_HDR_SEQ,
    ST_HDR_LEN,
    ST_PAYLOAD,
    ST_CRC,
    ST_TAIL
  } drain_state_e;

  localparam logic [7:0] IDLE_BYTE = 8'h00;
  localparam logic [7:0] CRC_POLY  = 8'h07;

  function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ CRC_POLY) : {c[6:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/line_buf.sv
// Dual-port line storage: one write port, one read port with a registered
// (one-cycle latency) read, holding both ping-pong line buffers.
module line_buf #(
  parameter int DEPTH = 128,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/line_scheduler.sv
// Buffers parser bytes into two ping-pong lines and drains one framed line per line_start.
// Optional macro DATATAPE_LINE_CRC_EN appends a CRC-8 byte after the payload.
//
// state       | meaning
// ST_IDLE     | waiting for line_start; px_req answered with 00
// ST_HDR_SYNC | next request gets SYNC_BYTE (00 on an idle line)
// ST_HDR_SEQ  | next request gets the line sequence number
// ST_HDR_LEN  | next request gets the line length (00 on an idle line)
// ST_PAYLOAD  | LINE_BYTES requests, bytes past the length read as 00
// ST_CRC      | next request gets the line CRC (CRC build only)
// ST_TAIL     | one cycle to bump seq, then back to idle
module line_scheduler
  import datatape_pkg::*;
#(
  parameter int         LINE_BYTES = 64,
  parameter logic [7:0] SYNC_BYTE  = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_last,
  input  logic       line_start,
  input  logic       px_req,
  output logic [7:0] px_data,
  output logic       px_valid,
  output logic       overrun
);

  localparam int PW = $clog2(LINE_BYTES);
  localparam int LW = PW + 1;
  localparam int AW = PW + 1;
  localparam logic [PW-1:0] LAST_IDX = PW'(LINE_BYTES - 1);

  drain_state_e state_q, state_d;

  logic                wr_sel_q, wr_sel_d;
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [1:0]          closed_q, closed_d;
  logic [1:0][LW-1:0]  len_q, len_d;
  logic                rd_sel_q, rd_sel_d;
  logic [PW-1:0]       cnt_q, cnt_d;
  logic                data_line_q, data_line_d;
  logic [7:0]          seq_q;
  logic                overrun_q;
  logic                in_ready_q, in_ready_d;
  logic                px_valid_q;
  logic                use_ram_q, use_ram_d;
  logic [7:0]          byte_q, byte_d;

  logic                fill_we, fill_close, release_buf, seq_inc, last_pay;
  logic [7:0]          ram_rdata;
  logic [LW-1:0]       rd_len;

  assign rd_len     = len_q[rd_sel_q];
  assign fill_we    = in_valid & in_ready_q;
  assign fill_close = fill_we & (in_last | (wr_ptr_q == LAST_IDX));
  assign last_pay   = (cnt_q == LAST_IDX);

  line_buf #(
    .DEPTH (2 * LINE_BYTES),
    .AW    (AW)
  ) u_line_buf (
    .clk_i   (clk),
    .we_i    (fill_we),
    .waddr_i ({wr_sel_q, wr_ptr_q}),
    .wdata_i (in_data),
    .raddr_i ({rd_sel_q, cnt_q}),
    .rdata_o (ram_rdata)
  );

  // Fill close and drain release always touch different buffers, so both apply.
  always_comb begin
    wr_sel_d = wr_sel_q;
    wr_ptr_d = wr_ptr_q;
    closed_d = closed_q;
    len_d    = len_q;
    rd_sel_d = rd_sel_q;
    if (fill_close) begin
      closed_d[wr_sel_q] = 1'b1;
      len_d[wr_sel_q]    = {1'b0, wr_ptr_q} + LW'(1);
      wr_ptr_d           = '0;
      wr_sel_d           = ~wr_sel_q;
    end else if (fill_we) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (release_buf) begin
      closed_d[rd_sel_q] = 1'b0;
      rd_sel_d           = ~rd_sel_q;
    end
    in_ready_d = ~closed_d[wr_sel_d];
  end

`ifdef DATATAPE_LINE_CRC_EN
  logic [7:0] crc_q, crc_cur;
  logic       feed_q;

  // The byte emitted last cycle is folded in as it appears on px_data.
  assign crc_cur = feed_q ? crc8_update(crc_q, px_data) : crc_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      crc_q  <= 8'h00;
      feed_q <= 1'b0;
    end else begin
      crc_q  <= (state_q == ST_IDLE) ? 8'h00 : crc_cur;
      feed_q <= px_req & (state_q inside {ST_HDR_SYNC, ST_HDR_SEQ, ST_HDR_LEN, ST_PAYLOAD});
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:     if (line_start) state_d = ST_HDR_SYNC;
      ST_HDR_SYNC: if (px_req) state_d = ST_HDR_SEQ;
      ST_HDR_SEQ:  if (px_req) state_d = ST_HDR_LEN;
      ST_HDR_LEN:  if (px_req) state_d = ST_PAYLOAD;
`ifdef DATATAPE_LINE_CRC_EN
      ST_PAYLOAD:  if (px_req && last_pay) state_d = ST_CRC;
      ST_CRC:      if (px_req) state_d = ST_TAIL;
`else
      ST_PAYLOAD:  if (px_req && last_pay) state_d = ST_TAIL;
`endif
      ST_TAIL:     state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    byte_d      = IDLE_BYTE;
    use_ram_d   = 1'b0;
    release_buf = 1'b0;
    seq_inc     = 1'b0;
    cnt_d       = cnt_q;
    data_line_d = data_line_q;
    unique case (state_q)
      ST_IDLE: begin
        if (line_start) begin
          data_line_d = closed_q[rd_sel_q];
          cnt_d       = '0;
        end
      end
      ST_HDR_SYNC: byte_d = data_line_q ? SYNC_BYTE : IDLE_BYTE;
      ST_HDR_SEQ:  byte_d = seq_q;
      // A full 256-byte line reports its length as 00 in the 8-bit field.
      ST_HDR_LEN:  byte_d = data_line_q ? 8'(rd_len) : IDLE_BYTE;
      ST_PAYLOAD: begin
        if (px_req) begin
          use_ram_d = data_line_q & ({1'b0, cnt_q} < rd_len);
          cnt_d     = cnt_q + PW'(1);
          if (last_pay && data_line_q) begin
            release_buf = 1'b1;
          end
        end
      end
`ifdef DATATAPE_LINE_CRC_EN
      ST_CRC:      byte_d = crc_cur;
`endif
      ST_TAIL:     seq_inc = data_line_q;
      default:     byte_d = IDLE_BYTE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_sel_q    <= 1'b0;
      wr_ptr_q    <= '0;
      closed_q    <= 2'b00;
      len_q       <= '0;
      rd_sel_q    <= 1'b0;
      cnt_q       <= '0;
      data_line_q <= 1'b0;
      seq_q       <= 8'h00;
      overrun_q   <= 1'b0;
      in_ready_q  <= 1'b0;
      px_valid_q  <= 1'b0;
      use_ram_q   <= 1'b0;
      byte_q      <= IDLE_BYTE;
    end else begin
      wr_sel_q    <= wr_sel_d;
      wr_ptr_q    <= wr_ptr_d;
      closed_q    <= closed_d;
      len_q       <= len_d;
      rd_sel_q    <= rd_sel_d;
      cnt_q       <= cnt_d;
      data_line_q <= data_line_d;
      seq_q       <= seq_q + {7'd0, seq_inc};
      overrun_q   <= overrun_q | (line_start & (state_q != ST_IDLE));
      in_ready_q  <= in_ready_d;
      px_valid_q  <= px_req;
      use_ram_q   <= px_req & use_ram_d;
      byte_q      <= px_req ? byte_d : IDLE_BYTE;
    end
  end

  assign in_ready = in_ready_q;
  assign px_valid = px_valid_q;
  assign px_data  = use_ram_q ? ram_rdata : byte_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_line_scheduler.sv
// Scoreboard bench for line_scheduler: a behavioural line model predicts every
// output byte when requests are driven; a negedge monitor pops and compares.
module tb_line_scheduler;

  localparam int LB = 64;
  localparam int LINE_LEN = LB + 3;

  logic       clk;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       in_last;
  logic       line_start;
  logic       px_req;
  logic [7:0] px_data;
  logic       px_valid;
  logic       overrun;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_q[$];
  logic [7:0] model_bytes[$];
  int         model_lens[$];
  int         cur_cnt  = 0;
  int         sent_cnt = 0;
  logic [7:0] mseq     = 8'h00;

  line_scheduler dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_last    (in_last),
    .line_start (line_start),
    .px_req     (px_req),
    .px_data    (px_data),
    .px_valid   (px_valid),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (px_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL px_unexpected: got %02h with nothing expected", px_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (px_data !== e) begin
          failures++;
          $display("FAIL px_data: got %02h expected %02h", px_data, e);
        end
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void model_push(input logic [7:0] b, input bit last);
    model_bytes.push_back(b);
    cur_cnt++;
    sent_cnt++;
    if (cur_cnt == LB || last) begin
      model_lens.push_back(cur_cnt);
      cur_cnt = 0;
    end
  endfunction

  function automatic void model_clear();
    model_bytes.delete();
    model_lens.delete();
    cur_cnt  = 0;
    sent_cnt = 0;
    mseq     = 8'h00;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; in_last = 1'b0; line_start = 1'b0; px_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_clear();
    @(negedge clk);
  endtask

  task automatic send_packet(input int n, input int base, input int max_cycles);
    int i = 0;
    int cyc = 0;
    while (i < n && cyc < max_cycles) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'(base + i);
      in_last  = (i == n - 1);
      if (in_ready === 1'b1) begin
        model_push(in_data, in_last);
        i++;
      end
      cyc++;
    end
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    checks++;
    if (i != n) begin
      failures++;
      $display("FAIL send_timeout: sent %0d of %0d bytes", i, n);
    end
  endtask

  // Pulse line_start, predict the line from the model, request n_req bytes.
  task automatic run_line(input int n_req, input int ovr_at, input bit watch_rel);
    logic [7:0] exp_line [LINE_LEN];
    int len;
    @(negedge clk);
    line_start = 1'b1;
    @(negedge clk);
    line_start = 1'b0;
    for (int i = 0; i < LINE_LEN; i++) exp_line[i] = 8'h00;
    exp_line[1] = mseq;
    if (model_lens.size() > 0) begin
      len = model_lens.pop_front();
      exp_line[0] = 8'hA5;
      exp_line[2] = 8'(len);
      for (int i = 0; i < LB; i++) begin
        if (i < len) exp_line[3 + i] = model_bytes.pop_front();
      end
      if (n_req == LINE_LEN) mseq = mseq + 8'd1;
    end
    for (int k = 0; k < n_req; k++) begin
      exp_q.push_back(exp_line[k]);
      px_req = 1'b1;
      line_start = (k == ovr_at);
      if (watch_rel && k == LINE_LEN - 1) begin
        checks++;
        if (in_ready !== 1'b0) begin
          failures++;
          $display("FAIL ready_before_release: got %b expected 0", in_ready);
        end
      end
      @(negedge clk);
    end
    px_req = 1'b0;
    line_start = 1'b0;
    if (watch_rel) begin
      checks++;
      if (in_ready !== 1'b1) begin
        failures++;
        $display("FAIL ready_after_release: got %b expected 1", in_ready);
      end
    end
    if (n_req == LINE_LEN) repeat (3) @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL %s_in_ready: got %b expected 0", tag, in_ready); end
    checks++;
    if (px_valid !== 1'b0) begin failures++; $display("FAIL %s_px_valid: got %b expected 0", tag, px_valid); end
    checks++;
    if (px_data !== 8'h00) begin failures++; $display("FAIL %s_px_data: got %02h expected 00", tag, px_data); end
    checks++;
    if (overrun !== 1'b0) begin failures++; $display("FAIL %s_overrun: got %b expected 0", tag, overrun); end
  endtask

  task automatic check_drained(input string tag);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_pending: got %0d bytes outstanding expected 0", tag, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00; line_start = 1'b0; px_req = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_release_ready: got %b expected 1", in_ready); end
    exp_q.push_back(8'h00);
    px_req = 1'b1;
    @(negedge clk);
    exp_q.push_back(8'h00);
    @(negedge clk);
    px_req = 1'b0;
    @(negedge clk);
    check_drained("reset");
  endtask

  task automatic test_short_packet();
    send_packet(10, 1, 100);
    run_line(LINE_LEN, -1, 1'b0);
    check_drained("short");
  endtask

  task automatic test_long_packet();
    do_reset();
    fork
      send_packet(130, 8'h20, 3000);
      begin
        repeat (140) @(negedge clk);
        run_line(LINE_LEN, -1, 1'b0);
        run_line(LINE_LEN, -1, 1'b0);
        run_line(LINE_LEN, -1, 1'b0);
      end
    join
    checks++;
    if (sent_cnt != 130) begin failures++; $display("FAIL long_sent: got %0d expected 130", sent_cnt); end
    check_drained("long");
  endtask

  task automatic test_back_to_back();
    do_reset();
    fork
      send_packet(200, 8'h40, 5000);
      begin
        repeat (150) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_ready: got %b expected 0", in_ready); end
        checks++;
        if (sent_cnt != 128) begin failures++; $display("FAIL stall_count: got %0d expected 128", sent_cnt); end
        run_line(LINE_LEN, -1, 1'b1);
        run_line(LINE_LEN, -1, 1'b0);
        run_line(LINE_LEN, -1, 1'b0);
        run_line(LINE_LEN, -1, 1'b0);
      end
    join
    check_drained("stall");
  endtask

  task automatic test_idle_line();
    do_reset();
    run_line(LINE_LEN, -1, 1'b0);
    send_packet(5, 8'h90, 100);
    run_line(LINE_LEN, -1, 1'b0);
    check_drained("idle");
  endtask

  task automatic test_overrun();
    do_reset();
    send_packet(10, 8'h60, 100);
    checks++;
    if (overrun !== 1'b0) begin failures++; $display("FAIL overrun_before: got %b expected 0", overrun); end
    run_line(LINE_LEN, 20, 1'b0);
    checks++;
    if (overrun !== 1'b1) begin failures++; $display("FAIL overrun_set: got %b expected 1", overrun); end
    send_packet(3, 8'h70, 100);
    run_line(LINE_LEN, -1, 1'b0);
    checks++;
    if (overrun !== 1'b1) begin failures++; $display("FAIL overrun_sticky: got %b expected 1", overrun); end
    check_drained("overrun");
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1; in_data = 8'(8'h80 + i); in_last = 1'b0;
      @(negedge clk);
    end
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check_reset_values("midfill");
    rst = 1'b1;
    model_clear();
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL midfill_ready: got %b expected 1", in_ready); end
    run_line(LINE_LEN, -1, 1'b0);
    check_drained("midfill");

    do_reset();
    send_packet(10, 8'hC0, 100);
    run_line(30, 15, 1'b0);
    checks++;
    if (overrun !== 1'b1) begin failures++; $display("FAIL middrain_overrun: got %b expected 1", overrun); end
    rst = 1'b0;
    @(negedge clk);
    check_reset_values("middrain");
    rst = 1'b1;
    model_clear();
    exp_q.delete();
    @(negedge clk);
    run_line(LINE_LEN, -1, 1'b0);
    check_drained("middrain");
  endtask

  initial begin
    test_reset();
    test_short_packet();
    test_long_packet();
    test_back_to_back();
    test_idle_line();
    test_overrun();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
